pipe_scoreboard: RTL and testbench
==================================

PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32, number of architectural registers; register 0 is hardwired zero and never pending.
REQ-002 Parameter REG_W, default 5, register index width; it SHALL satisfy 2**REG_W >= NUM_REGS.
REQ-003 Parameter MAX_LAT, default 8, largest writeback latency in cycles, range 2..15.
REQ-004 Parameter FWD_LAT, default 1, remaining-cycle threshold at or below which a pending result counts as forwardable.
REQ-005 Clock  input  1  the single clock; all state changes on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 ID_Valid  input  1  an instruction is present in the ID stage.
REQ-008 ID_RsReg, ID_RtReg  input  REG_W each  source register indices.
REQ-009 ID_UseRs, ID_UseRt  input  1 each  the corresponding source is actually read.
REQ-010 ID_RegWrite  input  1  the instruction writes ID_DestReg.
REQ-011 ID_DestReg  input  REG_W  destination register index.
REQ-012 ID_Latency  input  4  cycles from issue to writeback; 0 is treated as 1, and values above MAX_LAT are treated as MAX_LAT.
REQ-013 IF_Flush  input  1  the ID instruction is squashed this cycle.
REQ-014 Stall  output  1  the ID instruction is held this cycle.
REQ-015 PCWrite, IFID_Write  output  1 each  equal to ~Stall.
REQ-016 HazZero  output  1  equal to Stall; zeroes the ID/EX control word.
REQ-017 Issue  output  1  the ID instruction is accepted this cycle.
REQ-018 Busy  output  1  at least one register is pending.

Function
REQ-019 The block SHALL keep one counter per register, value c: a write to that register lands c cycles from now, and 0 means the register is not pending.
REQ-020 The block SHALL keep a writeback reservation vector, bits 0..MAX_LAT, where bit k set means the single writeback port is used k cycles from now.
REQ-021 RAW hazard: asserted when (ID_UseRs and Rs!=0 and cnt[Rs]>FWD_LAT) or (ID_UseRt and Rt!=0 and cnt[Rt]>FWD_LAT).
REQ-022 Port hazard: asserted when ID_RegWrite and Dest!=0 and reservation bit L is set, where L is the effective latency.
REQ-023 Stall SHALL equal ID_Valid and ~IF_Flush and (RAW hazard or port hazard or WAW hazard), computed combinationally from current state and ID inputs.
REQ-024 Issue SHALL equal ID_Valid and ~IF_Flush and ~Stall.
REQ-025 Every cycle, each nonzero counter SHALL decrement by 1, and the reservation vector SHALL shift right by 1.
REQ-026 On Issue with ID_RegWrite and Dest!=0, the next value of cnt[Dest] SHALL be L-1 (overriding that counter's decrement), and the next value of reservation bit L-1 SHALL be set.
REQ-027 Latency 1 leaves the counter at 0, so no stall is caused on the following instruction.
REQ-028 A stalled or flushed instruction SHALL change no state.
REQ-029 Busy SHALL be registered: it is the OR of all next-state counters, so it is valid one cycle after the state update.
REQ-030 The block has no other latency: Stall and Issue respond in the same cycle as their inputs.

Reset
REQ-031 On Clock with Reset=1, all counters, the reservation vector and Busy SHALL clear to 0.
REQ-032 Reset SHALL win over a simultaneous Issue.
REQ-033 In the cycle after reset: Stall=0, HazZero=0, PCWrite=1, IFID_Write=1, Busy=0.
REQ-034 Reset asserted mid-operation SHALL discard all pending entries.

Configuration
REQ-035 Macro PIPE_SCOREBOARD_WAW_EN defined: WAW hazard is asserted when ID_RegWrite and Dest!=0 and cnt[Dest]>L-1, preventing out-of-order overwrite.
REQ-036 Macro PIPE_SCOREBOARD_WAW_EN undefined: WAW hazard is constant 0, and a later issue simply overwrites cnt[Dest].

Verification
REQ-037 Reset, then ID_Valid=1, UseRs=1, Rs=3, cnt all 0 -> Stall=0, Issue=1, PCWrite=1, Busy=0.
REQ-038 Issue Dest=5, L=4; next cycle Rs=5 -> Stall=1 for 2 cycles (cnt 3, then 2), Issue in the third cycle (cnt=1<=FWD_LAT).
REQ-039 Issue Dest=6, L=3; next cycle Dest=7, L=2 -> port hazard, Stall=1 for one cycle, then Issue.
REQ-040 Rs=0 with cnt ignored, and Dest=0 issue -> no counter or reservation change, Stall=0.
REQ-041 RAW-stalled instruction with IF_Flush=1 -> Stall=0, Issue=0, state unchanged.
REQ-042 Issue Dest=9, L=8, then Dest=9, L=2, with WAW_EN defined -> Stall until cnt[9]<=1; with the macro undefined -> immediate Issue and cnt[9]=1.

Source files
------------

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: ID-stage issue scoreboard for an in-order pipeline with
// variable-latency writeback. It tracks per-register pending counters and a
// single-port writeback reservation vector, and stalls ID on RAW, writeback
// port and (optionally) WAW hazards.
// Optional feature: define PIPE_SCOREBOARD_WAW_EN to stall an instruction
// whose result would land before an older pending write to the same register.
module pipe_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned MAX_LAT  = 8,
  parameter int unsigned FWD_LAT  = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ID_Valid,
  input  logic [REG_W-1:0] ID_RsReg,
  input  logic [REG_W-1:0] ID_RtReg,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_RegWrite,
  input  logic [REG_W-1:0] ID_DestReg,
  input  logic [3:0]       ID_Latency,
  input  logic             IF_Flush,
  output logic             Stall,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             HazZero,
  output logic             Issue,
  output logic             Busy
);

  localparam int unsigned RSV_W = MAX_LAT + 1;

  // Pending-write counters (entry 0 stays zero), reservation vector, Busy.
  logic [3:0]       r_cnt [NUM_REGS];
  logic [RSV_W-1:0] r_rsv;
  logic             r_busy;

  logic [3:0]       w_lat;
  logic [3:0]       w_lat_m1;
  logic [3:0]       w_cnt_rs;
  logic [3:0]       w_cnt_rt;
  logic             w_dest_nz;
  logic             w_raw;
  logic             w_port;
  logic             w_waw;
  logic             w_stall;
  logic             w_issue;
  logic             w_wr;
  logic [3:0]       w_cnt_nxt [NUM_REGS];
  logic [RSV_W-1:0] w_rsv_nxt;
  logic             w_busy_nxt;

  // Effective latency: 0 behaves as 1, anything above MAX_LAT clamps to it.
  always_comb begin
    if (ID_Latency == 4'd0) begin
      w_lat = 4'd1;
    end else if (ID_Latency > 4'(MAX_LAT)) begin
      w_lat = 4'(MAX_LAT);
    end else begin
      w_lat = ID_Latency;
    end
    w_lat_m1 = w_lat - 4'd1;
  end

  // Source counter lookup; register 0 and out-of-range indices read as idle.
  always_comb begin
    w_cnt_rs = '0;
    w_cnt_rt = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (ID_RsReg == REG_W'(i)) w_cnt_rs = r_cnt[i];
      if (ID_RtReg == REG_W'(i)) w_cnt_rt = r_cnt[i];
    end
  end

  assign w_dest_nz = (ID_DestReg != '0);

  assign w_raw = (ID_UseRs && (ID_RsReg != '0) && (w_cnt_rs > 4'(FWD_LAT))) ||
                 (ID_UseRt && (ID_RtReg != '0) && (w_cnt_rt > 4'(FWD_LAT)));

  assign w_port = ID_RegWrite && w_dest_nz &&
                  (|(r_rsv & (RSV_W'(1) << w_lat)));

`ifdef PIPE_SCOREBOARD_WAW_EN
  logic [3:0] w_cnt_dst;

  // Destination counter lookup for the WAW ordering check.
  always_comb begin
    w_cnt_dst = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (ID_DestReg == REG_W'(i)) w_cnt_dst = r_cnt[i];
    end
  end

  assign w_waw = ID_RegWrite && w_dest_nz && (w_cnt_dst > w_lat_m1);
`else
  assign w_waw = 1'b0;
`endif

  assign w_stall = ID_Valid && !IF_Flush && (w_raw || w_port || w_waw);
  assign w_issue = ID_Valid && !IF_Flush && !w_stall;
  assign w_wr    = w_issue && ID_RegWrite && w_dest_nz;

  assign Stall      = w_stall;
  assign HazZero    = w_stall;
  assign PCWrite    = !w_stall;
  assign IFID_Write = !w_stall;
  assign Issue      = w_issue;
  assign Busy       = r_busy;

  // Next state: age every entry, then let an issuing write claim its slot.
  always_comb begin
    w_busy_nxt   = 1'b0;
    w_cnt_nxt[0] = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      w_cnt_nxt[i] = (r_cnt[i] != '0) ? (r_cnt[i] - 4'd1) : '0;
      if (w_wr && (ID_DestReg == REG_W'(i))) begin
        w_cnt_nxt[i] = w_lat_m1;
      end
      w_busy_nxt = w_busy_nxt | (w_cnt_nxt[i] != '0);
    end
    w_rsv_nxt = r_rsv >> 1;
    if (w_wr) begin
      w_rsv_nxt = w_rsv_nxt | (RSV_W'(1) << w_lat_m1);
    end
  end

  // State register with synchronous reset that overrides any issue.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
      r_rsv  <= '0;
      r_busy <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_rsv  <= w_rsv_nxt;
      r_busy <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed-vector bench for pipe_scoreboard: the driver pushes the
// hand-computed expectation of each cycle into a queue and a negedge
// monitor pops and compares the DUT outputs.
module tb_pipe_scoreboard;

  localparam int REG_W = 5;

  logic             Clock;
  logic             Reset;
  logic             ID_Valid;
  logic [REG_W-1:0] ID_RsReg;
  logic [REG_W-1:0] ID_RtReg;
  logic             ID_UseRs;
  logic             ID_UseRt;
  logic             ID_RegWrite;
  logic [REG_W-1:0] ID_DestReg;
  logic [3:0]       ID_Latency;
  logic             IF_Flush;
  logic             Stall;
  logic             PCWrite;
  logic             IFID_Write;
  logic             HazZero;
  logic             Issue;
  logic             Busy;

  pipe_scoreboard #(
    .NUM_REGS (32),
    .REG_W    (REG_W),
    .MAX_LAT  (8),
    .FWD_LAT  (1)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .ID_Valid    (ID_Valid),
    .ID_RsReg    (ID_RsReg),
    .ID_RtReg    (ID_RtReg),
    .ID_UseRs    (ID_UseRs),
    .ID_UseRt    (ID_UseRt),
    .ID_RegWrite (ID_RegWrite),
    .ID_DestReg  (ID_DestReg),
    .ID_Latency  (ID_Latency),
    .IF_Flush    (IF_Flush),
    .Stall       (Stall),
    .PCWrite     (PCWrite),
    .IFID_Write  (IFID_Write),
    .HazZero     (HazZero),
    .Issue       (Issue),
    .Busy        (Busy)
  );

  typedef struct {
    string nm;
    bit    chk;
    bit    st;
    bit    is;
    bit    bu;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge Clock) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        n_tests++;
        if (Stall !== e.st || HazZero !== e.st || PCWrite !== ~e.st ||
            IFID_Write !== ~e.st || Issue !== e.is || Busy !== e.bu) begin
          n_fail++;
          $display("FAIL %s: got Stall=%b HazZero=%b PCWrite=%b IFID_Write=%b Issue=%b Busy=%b, want Stall=%b HazZero=%b PCWrite=%b IFID_Write=%b Issue=%b Busy=%b",
                   e.nm, Stall, HazZero, PCWrite, IFID_Write, Issue, Busy,
                   e.st, e.st, ~e.st, ~e.st, e.is, e.bu);
        end
      end
    end
  end

  task automatic vec(input string nm, input bit chk, input bit rst,
                     input bit v, input bit urs, input int rs,
                     input bit urt, input int rt, input bit rw,
                     input int dst, input int lat, input bit fl,
                     input bit es, input bit ei, input bit eb);
    exp_t x;
    Reset       = rst;
    ID_Valid    = v;
    ID_UseRs    = urs;
    ID_RsReg    = REG_W'(rs);
    ID_UseRt    = urt;
    ID_RtReg    = REG_W'(rt);
    ID_RegWrite = rw;
    ID_DestReg  = REG_W'(dst);
    ID_Latency  = 4'(lat);
    IF_Flush    = fl;
    x.nm  = nm;
    x.chk = chk;
    x.st  = es;
    x.is  = ei;
    x.bu  = eb;
    q.push_back(x);
    @(posedge Clock);
    #1;
  endtask

  // Checked idle cycle: only Busy carries information.
  task automatic idle(input string nm, input bit eb);
    vec(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eb);
  endtask

  // Unchecked idle cycles to drain all pending state between groups.
  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      vec("settle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    Reset = 1'b1; ID_Valid = 1'b0; ID_UseRs = 1'b0; ID_UseRt = 1'b0;
    ID_RsReg = '0; ID_RtReg = '0; ID_RegWrite = 1'b0; ID_DestReg = '0;
    ID_Latency = '0; IF_Flush = 1'b0;
    @(posedge Clock);
    #1;
    vec("reset0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("reset1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Post-reset outputs
    idle("after_reset", 0);
    //   name          chk rst v  urs rs urt rt rw dst lat fl  st is bu
    vec("rs3_clean",     1, 0, 1, 1,  3, 0,  0, 0, 0,  0, 0,  0, 1, 0);

    // RAW: Dest=5 L=4, then Rs=5 stalls two cycles
    vec("iss_d5_l4",     1, 0, 1, 0,  0, 0,  0, 1, 5,  4, 0,  0, 1, 0);
    vec("raw5_cnt3",     1, 0, 1, 1,  5, 0,  0, 0, 0,  0, 0,  1, 0, 1);
    vec("raw5_cnt2",     1, 0, 1, 1,  5, 0,  0, 0, 0,  0, 0,  1, 0, 1);
    vec("raw5_cnt1",     1, 0, 1, 1,  5, 0,  0, 0, 0,  0, 0,  0, 1, 1);
    idle("raw5_drained", 0);
    settle(10);

    // Writeback port collision: Dest=6 L=3 then Dest=7 L=2
    vec("iss_d6_l3",     1, 0, 1, 0,  0, 0,  0, 1, 6,  3, 0,  0, 1, 0);
    vec("port_d7_l2",    1, 0, 1, 0,  0, 0,  0, 1, 7,  2, 0,  1, 0, 1);
    vec("iss_d7_l2",     1, 0, 1, 0,  0, 0,  0, 1, 7,  2, 0,  0, 1, 1);
    idle("d7_pending", 1);
    idle("d7_drained", 0);
    settle(10);

    // Dest=0 changes nothing; Rs=0 is never a hazard
    vec("iss_d0_l5",     1, 0, 1, 0,  0, 0,  0, 1, 0,  5, 0,  0, 1, 0);
    idle("d0_no_cnt", 0);
    vec("d4_l3_no_rsv",  1, 0, 1, 0,  0, 0,  0, 1, 4,  3, 0,  0, 1, 0);
    vec("rs0_ignored",   1, 0, 1, 1,  0, 0,  0, 0, 0,  0, 0,  0, 1, 1);
    settle(10);

    // Flush of a RAW-stalled writing instruction: no stall, no state change
    vec("iss_d8_l5",     1, 0, 1, 0,  0, 0,  0, 1, 8,  5, 0,  0, 1, 0);
    vec("flush_raw8",    1, 0, 1, 1,  8, 0,  0, 1, 10, 3, 1,  0, 0, 1);
    vec("no_d10_no_rsv", 1, 0, 1, 1, 10, 0,  0, 1, 11, 2, 0,  0, 1, 1);
    vec("raw8_cnt2",     1, 0, 1, 1,  8, 0,  0, 0, 0,  0, 0,  1, 0, 1);
    vec("raw8_cnt1",     1, 0, 1, 1,  8, 0,  0, 0, 0,  0, 0,  0, 1, 1);
    idle("d8_drained", 0);
    settle(10);

    // Latency 0 acts as 1: no counter, no stall on the consumer
    vec("iss_d11_l0",    1, 0, 1, 0,  0, 0,  0, 1, 11, 0, 0,  0, 1, 0);
    vec("rs11_no_stall", 1, 0, 1, 1, 11, 0,  0, 0, 0,  0, 0,  0, 1, 0);
    settle(10);

    // Latency 15 clamps to MAX_LAT=8: consumer stalls for counts 7..2
    vec("iss_d12_l15",   1, 0, 1, 0,  0, 0,  0, 1, 12, 15, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      vec("raw12_clamp", 1, 0, 1, 1, 12, 0,  0, 0, 0,  0, 0,  1, 0, 1);
    end
    vec("raw12_cnt1",    1, 0, 1, 1, 12, 0,  0, 0, 0,  0, 0,  0, 1, 1);
    idle("d12_drained", 0);
    settle(10);

    // Second write to register 9 with shorter latency
    vec("iss_d9_l8",     1, 0, 1, 0,  0, 0,  0, 1, 9,  8, 0,  0, 1, 0);
`ifdef PIPE_SCOREBOARD_WAW_EN
    for (int i = 0; i < 6; i++) begin
      vec("waw9_stall",  1, 0, 1, 0,  0, 0,  0, 1, 9,  2, 0,  1, 0, 1);
    end
    vec("waw9_issue",    1, 0, 1, 0,  0, 0,  0, 1, 9,  2, 0,  0, 1, 1);
`else
    vec("waw9_overwrite",1, 0, 1, 0,  0, 0,  0, 1, 9,  2, 0,  0, 1, 1);
`endif
    idle("d9_cnt1", 1);
    idle("d9_drained", 0);
    settle(10);

    // Reset mid-operation, with a simultaneous issue that must be dropped
    vec("iss_d13_l6",    1, 0, 1, 0,  0, 0,  0, 1, 13, 6, 0,  0, 1, 0);
    vec("rst_with_iss",  0, 1, 1, 0,  0, 0,  0, 1, 14, 5, 0,  0, 0, 0);
    vec("post_rst_clean",1, 0, 1, 1, 13, 1, 14, 1, 15, 4, 0,  0, 1, 0);
    idle("d15_cnt3", 1);
    idle("d15_cnt2", 1);
    idle("d15_cnt1", 1);
    idle("d15_drained", 0);

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge Clock);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
